rgb_hue_sequencer: RTL and testbench

Generates the three PWM duty words that sweep an RGB LED around the hue wheel. Sits directly upstream of the per-channel `PWM_ENHANCED` instances and feeds their `duty` inputs. It replaces ad-hoc duty logic in top-level wrappers with one clock-domain sequencer: prescaler, six-phase FSM, and saturating channel ramps. Speed and step size are selected from board switches.

---
 rtl/rgb_hue_sequencer.sv | 154 +++++++++++++++
 tb/tb_rgb_hue_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer
//   Produces the three PWM duty words that sweep an RGB LED around the hue
//   wheel. A prescaler generates ramp ticks. A six-phase FSM picks the one
//   channel that moves, and the direction it moves. Each ramp saturates at
//   0 or FS, so every phase ends exactly on its endpoint.
//
//   Optional feature: define RGB_SEQ_PAUSE_EN so that sw[3] freezes the
//   prescaler. When the macro is undefined, sw[3] is ignored.
//
// Ports
//   clk      : system clock
//   rst      : synchronous, active-high reset
//   sw[1:0]  : speed shift (tick period = TICK_DIV << sw[1:0]), latched at each tick
//   sw[2]    : coarse step (4 instead of 1)
//   sw[3]    : pause (RGB_SEQ_PAUSE_EN builds only)
//   duty_r/g/b : R+1-bit duty words, range 0..2**R
//   step_stb : one-cycle pulse in the cycle the duty words change
//   phase    : current hue phase, 0..5
module rgb_hue_sequencer #(
   parameter int unsigned R        = 8,
   parameter int unsigned TICK_DIV = 1250000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   sw,
   output logic [R:0]   duty_r,
   output logic [R:0]   duty_g,
   output logic [R:0]   duty_b,
   output logic         step_stb,
   output logic [2:0]   phase
);

   localparam logic [R+1:0] Fs      = {2'b01, {R{1'b0}}};
   localparam logic [31:0]  TickDiv = 32'(TICK_DIV);

   // Encoding equals the exported phase number.
   typedef enum logic [2:0] {
      StGUp   = 3'd0,
      StRDown = 3'd1,
      StBUp   = 3'd2,
      StGDown = 3'd3,
      StRUp   = 3'd4,
      StBDown = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [31:0]   term;
   logic [1:0]    spd_q, spd_d;
   logic [R:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic          stb_q, stb_d;
   logic          pause, tick;
   logic [R+1:0]  stp, cur, nxt;
   logic          up, hit;

`ifdef RGB_SEQ_PAUSE_EN
   assign pause = sw[3];
`else
   logic unused_pause;
   assign unused_pause = sw[3];
   assign pause        = 1'b0;
`endif

   // Prescaler: spd only changes at a tick, so a period never changes length midway.
   assign term = (TickDiv << spd_q) - 32'd1;
   assign tick = ~pause & (cnt_q == term);

   always_comb begin
      cnt_d = cnt_q;
      spd_d = spd_q;
      if (tick) begin
         cnt_d = '0;
         spd_d = sw[1:0];
      end else if (!pause) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Ramp datapath. It is R+2 bits wide so that cur + stp cannot wrap before saturation.
   always_comb begin
      up  = 1'b0;
      cur = '0;
      case (state_q)
         StGUp:   begin up = 1'b1; cur = {1'b0, g_q}; end
         StRDown: cur = {1'b0, r_q};
         StBUp:   begin up = 1'b1; cur = {1'b0, b_q}; end
         StGDown: cur = {1'b0, g_q};
         StRUp:   begin up = 1'b1; cur = {1'b0, r_q}; end
         default: cur = {1'b0, b_q};
      endcase
      stp = sw[2] ? (R+2)'(4) : (R+2)'(1);
      if (up) begin
         nxt = ((cur + stp) > Fs) ? Fs : (cur + stp);
         hit = (nxt == Fs);
      end else begin
         nxt = (cur < stp) ? '0 : (cur - stp);
         hit = (nxt == '0);
      end
   end

   // FSM next state and channel updates.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      stb_d   = tick;
      if (tick) begin
         case (state_q)
            StGUp, StGDown: g_d = nxt[R:0];
            StRDown, StRUp: r_d = nxt[R:0];
            default:        b_d = nxt[R:0];
         endcase
         // The phase advances on the same tick that reaches the endpoint.
         if (hit) begin
            case (state_q)
               StGUp:   state_d = StRDown;
               StRDown: state_d = StBUp;
               StBUp:   state_d = StGDown;
               StGDown: state_d = StRUp;
               StRUp:   state_d = StBDown;
               default: state_d = StGUp;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         spd_q   <= '0;
         state_q <= StGUp;
         r_q     <= Fs[R:0];
         g_q     <= '0;
         b_q     <= '0;
         stb_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         spd_q   <= spd_d;
         state_q <= state_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         stb_q   <= stb_d;
      end
   end

   assign duty_r   = r_q;
   assign duty_g   = g_q;
   assign duty_b   = b_q;
   assign step_stb = stb_q;
   assign phase    = state_q;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// tb_rgb_hue_sequencer
//   Self-checking bench for rgb_hue_sequencer (R=8, TICK_DIV=4). A behavioural
//   hue-wheel model in the bench is compared with the DUT on every cycle.
//   Directed scenarios with literal expectations cover reset, ramps, speed,
//   pause and reset during operation. A randomized switch/reset phase follows.
module tb_rgb_hue_sequencer;

   localparam int R  = 8;
   localparam int TD = 4;
   localparam int FS = 256;
`ifdef RGB_SEQ_PAUSE_EN
   localparam bit PauseEn = 1'b1;
`else
   localparam bit PauseEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    sw  = 4'd0;
   logic [R:0]    duty_r, duty_g, duty_b;
   logic          step_stb;
   logic [2:0]    phase;

   int checks = 0;
   int errors = 0;

   rgb_hue_sequencer #(
      .R        (R),
      .TICK_DIV (TD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .duty_r   (duty_r),
      .duty_g   (duty_g),
      .duty_b   (duty_b),
      .step_stb (step_stb),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model. The channel order is 0=r, 1=g, 2=b.
   // Phase p moves channel chan[p], upward when rise[p] is set.
   int m_d[3];
   int m_ph, m_cnt, m_spd, m_c, m_s;
   bit m_stb;
   bit m_valid = 1'b0;
   int chan[6] = '{1, 0, 2, 1, 0, 2};
   bit rise[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_cnt = 0; m_spd = 0; m_ph = 0; m_stb = 1'b0;
            m_d[0] = FS; m_d[1] = 0; m_d[2] = 0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            m_stb = 1'b0;
            if (!(PauseEn && sw[3])) begin
               if (m_cnt == (TD << m_spd) - 1) begin
                  m_c = chan[m_ph];
                  m_s = sw[2] ? 4 : 1;
                  if (rise[m_ph]) begin
                     m_d[m_c] = (m_d[m_c] + m_s > FS) ? FS : m_d[m_c] + m_s;
                     if (m_d[m_c] == FS) m_ph = (m_ph + 1) % 6;
                  end else begin
                     m_d[m_c] = (m_d[m_c] < m_s) ? 0 : m_d[m_c] - m_s;
                     if (m_d[m_c] == 0) m_ph = (m_ph + 1) % 6;
                  end
                  m_spd = int'(sw[1:0]);
                  m_cnt = 0;
                  m_stb = 1'b1;
               end else begin
                  m_cnt++;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         check("duty_r", int'(duty_r), m_d[0]);
         check("duty_g", int'(duty_g), m_d[1]);
         check("duty_b", int'(duty_b), m_d[2]);
         check("phase", int'(phase), m_ph);
         check("step_stb", int'(step_stb), int'(m_stb));
         check("duty_range", int'(duty_r <= FS && duty_g <= FS && duty_b <= FS), 1);
      end
   end

   // Counts cycles up to and including the next visible strobe.
   task automatic wait_stb(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (step_stb !== 1'b1 && n < budget);
      if (step_stb !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL strobe_timeout: got no strobe, expected one within %0d cycles", budget);
      end
   endtask

   task automatic skip_stb(input int k);
      int n;
      repeat (k) wait_stb(100, n);
   endtask

   task automatic check_rgbp(input string name, input int r, input int g, input int b,
                             input int p);
      check({name, "_r"}, int'(duty_r), r);
      check({name, "_g"}, int'(duty_g), g);
      check({name, "_b"}, int'(duty_b), b);
      check({name, "_phase"}, int'(phase), p);
   endtask

   initial begin
      int n, cnt, hr, hg, hb;
      rst = 1'b1;
      sw  = 4'd0;
      repeat (3) @(negedge clk);
      check_rgbp("reset", 256, 0, 0, 0);
      check("reset_stb", int'(step_stb), 0);

      // Base ramp.
      rst = 1'b0;
      wait_stb(20, n);
      check("first_strobe_latency", n, 4);
      check("first_strobe_g", int'(duty_g), 1);
      wait_stb(20, n);
      check("base_spacing", n, 4);
      skip_stb(254);
      check_rgbp("after256", 256, 256, 0, 1);
      wait_stb(20, n);
      check_rgbp("strobe257", 255, 256, 0, 1);

      // Reset during P3 when g reaches 100 (strobe 924).
      skip_stb(924 - 257);
      check_rgbp("p3_g100", 0, 100, 256, 3);
      rst = 1'b1;
      @(negedge clk);
      check_rgbp("mid_reset", 256, 0, 0, 0);
      check("mid_reset_stb", int'(step_stb), 0);
      rst = 1'b0;
      wait_stb(20, n);
      check("restart_latency", n, 4);

      // Change the speed mid-period. The current period keeps its length.
      @(negedge clk);
      sw = 4'b0011;
      wait_stb(100, n);
      check("speed_old_period", n, 3);
      wait_stb(100, n);
      check("speed_new_period1", n, 32);
      wait_stb(100, n);
      check("speed_new_period2", n, 32);
      sw = 4'b0000;
      wait_stb(100, n);
      check("speed_back_old", n, 32);
      wait_stb(100, n);
      check("speed_back_new", n, 4);

      // Coarse wheel.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sw  = 4'b0100;
      skip_stb(64);
      check_rgbp("coarse64", 256, 256, 0, 1);
      skip_stb(320);
      check_rgbp("coarse384", 256, 0, 0, 0);

      // Pause, applied with the prescaler count at 2.
      sw = 4'b0000;
      wait_stb(20, n);
      repeat (2) @(negedge clk);
      sw  = 4'b1000;
      hr  = int'(duty_r); hg = int'(duty_g); hb = int'(duty_b);
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (step_stb) cnt++;
      end
`ifdef RGB_SEQ_PAUSE_EN
      check("pause_strobes", cnt, 0);
      check_rgbp("pause_frozen", hr, hg, hb, 0);
      sw = 4'b0000;
      wait_stb(20, n);
      check("pause_resume", n, 2);
`else
      check("pause_ignored_strobes", cnt, 25);
      check("pause_ignored_g", int'(duty_g), hg + 25);
      sw = 4'b0000;
`endif

      // Randomized switches with occasional resets.
      for (int i = 0; i < 60; i++) begin
         sw = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         repeat ($urandom_range(1, 150)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected completion before 2000000 time units");
      $fatal(1);
   end

endmodule
